// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTYPEEX,
    RTYPEWB,
    BEQEX,
    BNEEX,
    ADDIEX,
    ADDIWB,
    JEX
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_BNE   = 2'b11;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the controller's aluop and the R-type funct field to an ALU operation.
module aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = 3'b000;
    unique case (aluop)
      ALUOP_ADD: alucontrol = 3'b010;
      ALUOP_SUB: alucontrol = 3'b110;
      ALUOP_BNE: alucontrol = 3'b101;
      ALUOP_RTYPE: begin
        case (funct)
          6'b000011: alucontrol = 3'b010;
          6'b000100: alucontrol = 3'b110;
          6'b000000: alucontrol = 3'b000;
          6'b000001: alucontrol = 3'b001;
          6'b001100: alucontrol = 3'b111;
          6'b001001: alucontrol = 3'b011;
          6'b000010: alucontrol = 3'b100;
          default:   alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS main controller: Moore FSM for datapath enables/selects plus a retired-instruction counter.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             irwrite,
  output logic             pcen,
  output logic             regwrite,
  output logic             memwrite,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret
);

  state_t     state, state_next;
  logic [1:0] aluop;
  logic       retire;
  logic       mem_req_s, irwrite_s, pcen_s, regwrite_s, memwrite_s, illegal_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state <= state_next;
      if (retire) instret <= instret + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    mem_req_s  = 1'b0;
    irwrite_s  = 1'b0;
    pcen_s     = 1'b0;
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    illegal_s  = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = ALUOP_ADD;
    unique case (state)
      FETCH: begin
        mem_req_s = 1'b1;
        alusrcb   = 2'b01;
        irwrite_s = mem_ready;
        pcen_s    = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = RTYPEEX;
          OP_BEQ:       state_next = BEQEX;
          OP_BNE:       state_next = BNEEX;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JEX;
          default: begin
            illegal_s  = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        // op is still held in the instruction register; anything other than lw is sw here
        state_next = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req_s = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        mem_req_s  = 1'b1;
        iord       = 1'b1;
        memwrite_s = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_RTYPE;
        state_next = RTYPEWB;
      end
      RTYPEWB: begin
        regwrite_s = 1'b1;
        regdst     = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      BEQEX, BNEEX: begin
        alusrca    = 1'b1;
        pcsrc      = 2'b01;
        aluop      = (state == BEQEX) ? ALUOP_SUB : ALUOP_BNE;
        pcen_s     = (state == BEQEX) ? zero : ~zero;
        retire     = 1'b1;
        state_next = FETCH;
      end
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        regwrite_s = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      JEX: begin
        pcsrc      = 2'b10;
        pcen_s     = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // Strobes that commit architectural state are suppressed while reset is held.
  always_comb begin
    mem_req    = mem_req_s  & ~reset;
    irwrite    = irwrite_s  & ~reset;
    pcen       = pcen_s     & ~reset;
    regwrite   = regwrite_s & ~reset;
    memwrite   = memwrite_s & ~reset;
    illegal_op = illegal_s  & ~reset;
  end

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: cycle-by-cycle vector table plus a counter-wrap sequence.
module tb_mc_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    op, funct;
  logic          zero, mem_ready;
  logic          mem_req, irwrite, pcen, regwrite, memwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0]    alusrcb, pcsrc;
  logic [2:0]    alucontrol;
  logic          illegal_op;
  logic [CW-1:0] instret;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal_op (illegal_op),
    .instret    (instret)
  );

  // outs = {mem_req,irwrite,pcen,regwrite,memwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,alucontrol,illegal_op}
  typedef struct {
    logic          rst;
    logic [5:0]    op;
    logic [5:0]    fn;
    logic          z;
    logic          rdy;
    logic [16:0]   outs;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [16:0] actual_outs();
    return {mem_req, irwrite, pcen, regwrite, memwrite, iord, memtoreg, regdst,
            alusrca, alusrcb, pcsrc, alucontrol, illegal_op};
  endfunction

  task automatic add(input logic rst, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic rdy,
                     input logic mr, input logic irw, input logic pce, input logic rw,
                     input logic mw, input logic io, input logic m2r, input logic rd,
                     input logic asa, input logic [1:0] asb, input logic [1:0] pcs,
                     input logic [2:0] aluc, input logic ill, input logic [CW-1:0] cnt);
    vec_t v;
    v.rst = rst; v.op = o; v.fn = f; v.z = z; v.rdy = rdy;
    v.outs = {mr, irw, pce, rw, mw, io, m2r, rd, asa, asb, pcs, aluc, ill};
    v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string name, input logic [16:0] want);
    n_tests++;
    if (actual_outs() !== want) begin
      n_fail++;
      $display("FAIL %s outs got %b want %b", name, actual_outs(), want);
    end
  endtask

  task automatic check_cnt(input string name, input logic [CW-1:0] want);
    n_tests++;
    if (instret !== want) begin
      n_fail++;
      $display("FAIL %s instret got %0d want %0d", name, instret, want);
    end
  endtask

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                         BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  initial begin
    // rst op fn z rdy | mr irw pce rw mw io m2r rd asa asb pcs aluc ill | cnt
    add(1, R,    6'd0,  0, 1,  0,0,0,0,0,0,0,0,0, 2'b01,2'b00,3'b010,0, 0); // reset held in FETCH
    // R-type funct 000011: FETCH DECODE RTYPEEX RTYPEWB
    add(0, R,    6'd3,  0, 1,  1,1,1,0,0,0,0,0,0, 2'b01,2'b00,3'b010,0, 0);
    add(0, R,    6'd3,  0, 1,  0,0,0,0,0,0,0,0,0, 2'b11,2'b00,3'b010,0, 0);
    add(0, R,    6'd3,  0, 1,  0,0,0,0,0,0,0,0,1, 2'b00,2'b00,3'b010,0, 0);
    add(0, R,    6'd3,  0, 1,  0,0,0,1,0,0,0,1,0, 2'b00,2'b00,3'b010,0, 0);
    // R-type funct 001100 -> 111
    add(0, R,    6'h0c, 0, 1,  1,1,1,0,0,0,0,0,0, 2'b01,2'b00,3'b010,0, 1);
    add(0, R,    6'h0c, 0, 1,  0,0,0,0,0,0,0,0,0, 2'b11,2'b00,3'b010,0, 1);
    add(0, R,    6'h0c, 0, 1,  0,0,0,0,0,0,0,0,1, 2'b00,2'b00,3'b111,0, 1);
    add(0, R,    6'h0c, 0, 1,  0,0,0,1,0,0,0,1,0, 2'b00,2'b00,3'b010,0, 1);
    // R-type unknown funct -> 000
    add(0, R,    6'h3f, 0, 1,  1,1,1,0,0,0,0,0,0, 2'b01,2'b00,3'b010,0, 2);
    add(0, R,    6'h3f, 0, 1,  0,0,0,0,0,0,0,0,0, 2'b11,2'b00,3'b010,0, 2);
    add(0, R,    6'h3f, 0, 1,  0,0,0,0,0,0,0,0,1, 2'b00,2'b00,3'b000,0, 2);
    add(0, R,    6'h3f, 0, 1,  0,0,0,1,0,0,0,1,0, 2'b00,2'b00,3'b010,0, 2);
    // lw with a fetch wait and three MEMRD waits
    add(0, LW,   6'd0,  0, 0,  1,0,0,0,0,0,0,0,0, 2'b01,2'b00,3'b010,0, 3);
    add(0, LW,   6'd0,  0, 1,  1,1,1,0,0,0,0,0,0, 2'b01,2'b00,3'b010,0, 3);
    add(0, LW,   6'd0,  0, 1,  0,0,0,0,0,0,0,0,0, 2'b11,2'b00,3'b010,0, 3);
    add(0, LW,   6'd0,  0, 0,  0,0,0,0,0,0,0,0,1, 2'b10,2'b00,3'b010,0, 3);
    add(0, LW,   6'd0,  0, 0,  1,0,0,0,0,1,0,0,0, 2'b00,2'b00,3'b010,0, 3);
    add(0, LW,   6'd0,  0, 0,  1,0,0,0,0,1,0,0,0, 2'b00,2'b00,3'b010,0, 3);
    add(0, LW,   6'd0,  0, 0,  1,0,0,0,0,1,0,0,0, 2'b00,2'b00,3'b010,0, 3);
    add(0, LW,   6'd0,  0, 1,  1,0,0,0,0,1,0,0,0, 2'b00,2'b00,3'b010,0, 3);
    add(0, LW,   6'd0,  0, 1,  0,0,0,1,0,0,1,0,0, 2'b00,2'b00,3'b010,0, 3);
    // sw
    add(0, SW,   6'd0,  0, 1,  1,1,1,0,0,0,0,0,0, 2'b01,2'b00,3'b010,0, 4);
    add(0, SW,   6'd0,  0, 1,  0,0,0,0,0,0,0,0,0, 2'b11,2'b00,3'b010,0, 4);
    add(0, SW,   6'd0,  0, 1,  0,0,0,0,0,0,0,0,1, 2'b10,2'b00,3'b010,0, 4);
    add(0, SW,   6'd0,  0, 1,  1,0,0,0,1,1,0,0,0, 2'b00,2'b00,3'b010,0, 4);
    // beq taken, beq not taken
    add(0, BEQ,  6'd0,  1, 1,  1,1,1,0,0,0,0,0,0, 2'b01,2'b00,3'b010,0, 5);
    add(0, BEQ,  6'd0,  1, 1,  0,0,0,0,0,0,0,0,0, 2'b11,2'b00,3'b010,0, 5);
    add(0, BEQ,  6'd0,  1, 1,  0,0,1,0,0,0,0,0,1, 2'b00,2'b01,3'b110,0, 5);
    add(0, BEQ,  6'd0,  0, 1,  1,1,1,0,0,0,0,0,0, 2'b01,2'b00,3'b010,0, 6);
    add(0, BEQ,  6'd0,  0, 1,  0,0,0,0,0,0,0,0,0, 2'b11,2'b00,3'b010,0, 6);
    add(0, BEQ,  6'd0,  0, 1,  0,0,0,0,0,0,0,0,1, 2'b00,2'b01,3'b110,0, 6);
    // bne taken, bne not taken
    add(0, BNE,  6'd0,  0, 1,  1,1,1,0,0,0,0,0,0, 2'b01,2'b00,3'b010,0, 7);
    add(0, BNE,  6'd0,  0, 1,  0,0,0,0,0,0,0,0,0, 2'b11,2'b00,3'b010,0, 7);
    add(0, BNE,  6'd0,  0, 1,  0,0,1,0,0,0,0,0,1, 2'b00,2'b01,3'b101,0, 7);
    add(0, BNE,  6'd0,  1, 1,  1,1,1,0,0,0,0,0,0, 2'b01,2'b00,3'b010,0, 8);
    add(0, BNE,  6'd0,  1, 1,  0,0,0,0,0,0,0,0,0, 2'b11,2'b00,3'b010,0, 8);
    add(0, BNE,  6'd0,  1, 1,  0,0,0,0,0,0,0,0,1, 2'b00,2'b01,3'b101,0, 8);
    // addi
    add(0, ADDI, 6'd0,  0, 1,  1,1,1,0,0,0,0,0,0, 2'b01,2'b00,3'b010,0, 9);
    add(0, ADDI, 6'd0,  0, 1,  0,0,0,0,0,0,0,0,0, 2'b11,2'b00,3'b010,0, 9);
    add(0, ADDI, 6'd0,  0, 1,  0,0,0,0,0,0,0,0,1, 2'b10,2'b00,3'b010,0, 9);
    add(0, ADDI, 6'd0,  0, 1,  0,0,0,1,0,0,0,0,0, 2'b00,2'b00,3'b010,0, 9);
    // illegal opcode: one-cycle pulse, back to FETCH, count unchanged
    add(0, BAD,  6'd0,  0, 1,  1,1,1,0,0,0,0,0,0, 2'b01,2'b00,3'b010,0, 10);
    add(0, BAD,  6'd0,  0, 1,  0,0,0,0,0,0,0,0,0, 2'b11,2'b00,3'b010,1, 10);
    add(0, J,    6'd0,  0, 1,  1,1,1,0,0,0,0,0,0, 2'b01,2'b00,3'b010,0, 10);
    // j
    add(0, J,    6'd0,  0, 1,  0,0,0,0,0,0,0,0,0, 2'b11,2'b00,3'b010,0, 10);
    add(0, J,    6'd0,  0, 1,  0,0,1,0,0,0,0,0,0, 2'b00,2'b10,3'b010,0, 10);
    // sw stalled in MEMWR, then reset mid-wait
    add(0, SW,   6'd0,  0, 1,  1,1,1,0,0,0,0,0,0, 2'b01,2'b00,3'b010,0, 11);
    add(0, SW,   6'd0,  0, 1,  0,0,0,0,0,0,0,0,0, 2'b11,2'b00,3'b010,0, 11);
    add(0, SW,   6'd0,  0, 1,  0,0,0,0,0,0,0,0,1, 2'b10,2'b00,3'b010,0, 11);
    add(0, SW,   6'd0,  0, 0,  1,0,0,0,1,1,0,0,0, 2'b00,2'b00,3'b010,0, 11);
    add(1, SW,   6'd0,  0, 0,  0,0,0,0,0,1,0,0,0, 2'b00,2'b00,3'b010,0, 11);
    add(0, J,    6'd0,  0, 0,  1,0,0,0,0,0,0,0,0, 2'b01,2'b00,3'b010,0, 0);

    reset = 1'b1; op = R; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; op = vecs[i].op; funct = vecs[i].fn;
      zero = vecs[i].z; mem_ready = vecs[i].rdy;
      @(negedge clk);
      check_outs($sformatf("row%0d", i), vecs[i].outs);
      check_cnt($sformatf("row%0d", i), vecs[i].cnt);
      @(posedge clk); #1;
    end

    // 16 back-to-back jumps on a 4-bit counter: 0..15 then wrap to 0
    reset = 1'b0; op = J; mem_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check_cnt($sformatf("jwrap_fetch%0d", k), CW'(k));
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check_outs($sformatf("jwrap_jex%0d", k),
                 {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,3'b010,1'b0});
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_cnt("jwrap_final", '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout instret got %0d want end-of-test", instret);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The parameter list SHALL be: CNT_W, 32, width of the retired-instruction counter.
REQ-002 Port clk  input  1  is the single clock; all state changes occur on its rising edge.
REQ-003 Port reset  input  1  is the reset; it is synchronous and active-high.
REQ-004 Port op  input  6  is the opcode field of the instruction register.
REQ-005 Port funct  input  6  is the funct field of the instruction register, used for R-type decode.
REQ-006 Port zero  input  1  is the ALU zero flag.
REQ-007 Port mem_ready  input  1  means memory completes the current access this cycle.
REQ-008 Port mem_req  output  1  requests a memory access.
REQ-009 Ports irwrite, pcen, regwrite, memwrite, iord, memtoreg, regdst and alusrca are each an output of width 1 carrying the datapath enables and selects.
REQ-010 Port alusrcb  output  2  is the ALU B-operand select (00 reg, 01 const 4, 10 signimm, 11 signimm<<2).
REQ-011 Port pcsrc  output  2  is the PC source select (00 ALU result, 01 ALUOut, 10 jump target).
REQ-012 Port alucontrol  output  3  is the ALU operation code.
REQ-013 Port illegal_op  output  1  is a one-cycle pulse flagging an undefined opcode.
REQ-014 Port instret  output  CNT_W  is the count of retired instructions.

Function
REQ-015 The opcodes SHALL be: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
REQ-016 The controller SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BNEEX, ADDIEX, ADDIWB, JEX; the only Mealy terms SHALL be the mem_ready qualification of irwrite/pcen and the zero qualification of pcen.
REQ-017 In FETCH, mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00 and pcsrc=00; irwrite and pcen SHALL both equal mem_ready; the FSM stays in FETCH while mem_ready=0 and goes to DECODE when mem_ready=1.
REQ-018 In DECODE, alusrca=0, alusrcb=11 and aluop=00; next state is MEMADR for lw/sw, RTYPEEX for R-type, BEQEX for beq, BNEEX for bne, ADDIEX for addi and JEX for j; any other opcode SHALL assert illegal_op for that cycle and return to FETCH.
REQ-019 In MEMADR, alusrca=1, alusrcb=10 and aluop=00; next state is MEMRD for lw and MEMWR for sw.
REQ-020 In MEMRD, mem_req=1 and iord=1; the FSM holds until mem_ready=1, then goes to MEMWB.
REQ-021 In MEMWB, regwrite=1, memtoreg=1 and regdst=0; next state is FETCH.
REQ-022 In MEMWR, mem_req=1, iord=1 and memwrite=1; the FSM holds until mem_ready=1, then goes to FETCH.
REQ-023 In RTYPEEX, alusrca=1, alusrcb=00 and aluop=10; next state is RTYPEWB.
REQ-024 In RTYPEWB, regwrite=1, regdst=1 and memtoreg=0; next state is FETCH.
REQ-025 In BEQEX, alusrca=1, alusrcb=00, aluop=01, pcsrc=01 and pcen=zero; next state is FETCH.
REQ-026 In BNEEX, the outputs SHALL be as in BEQEX except aluop=11 and pcen=~zero; next state is FETCH.
REQ-027 In ADDIEX, alusrca=1, alusrcb=10 and aluop=00; next state is ADDIWB.
REQ-028 In ADDIWB, regwrite=1, regdst=0 and memtoreg=0; next state is FETCH.
REQ-029 In JEX, pcsrc=10 and pcen=1; next state is FETCH.
REQ-030 Every enable or select not listed for a state SHALL be 0.
REQ-031 alucontrol SHALL be derived combinationally from aluop and funct: 00->010, 01->110, 11->101; for 10, funct maps 000011->010, 000100->110, 000000->000, 000001->001, 001100->111, 001001->011, 000010->100, and any other funct -> 000.
REQ-032 With mem_ready=1 the latencies in cycles SHALL be: R-type 4, lw 5, sw 4, addi 4, beq 3, bne 3, j 3; each additional wait cycle adds one.
REQ-033 instret SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, RTYPEWB, BEQEX, BNEEX, ADDIWB or JEX, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-034 An illegal-opcode return to FETCH SHALL NOT increment instret.

Reset
REQ-035 When reset=1 at a rising edge, the state SHALL become FETCH and instret SHALL become 0, regardless of the current state, including mid-wait in MEMRD or MEMWR.
REQ-036 While reset=1, irwrite, pcen, regwrite, memwrite, mem_req and illegal_op SHALL be forced to 0.

Structure
REQ-037 Package mc_pkg SHALL hold the state enum, the opcode constants and the aluop constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_RTYPE=10, ALUOP_BNE=11).
REQ-038 mc_ctrl SHALL instantiate the existing aludec as its only sub-module to produce alucontrol.

Verification
REQ-039 Scenario: reset, then op=000000, funct=000011, mem_ready=1 -> states FETCH, DECODE, RTYPEEX, RTYPEWB; alucontrol=010 in RTYPEEX; regwrite=1 and regdst=1 in cycle 4; instret goes 0->1.
REQ-040 Scenario: op=100011 with mem_ready=0 for 3 cycles in MEMRD -> the FSM stays in MEMRD with mem_req=1, iord=1 and regwrite=0; it then enters MEMWB with memtoreg=1 and regwrite=1.
REQ-041 Scenario: beq with zero=1 -> pcen=1, pcsrc=01, alucontrol=110; beq with zero=0 -> pcen=0; bne with zero=0 -> pcen=1, alucontrol=101.
REQ-042 Scenario: op=111111 -> illegal_op=1 for exactly the DECODE cycle, the next state is FETCH, and instret is unchanged.
REQ-043 Scenario: reset asserted in MEMWR while memwrite=1 -> memwrite=0 immediately, state is FETCH after the edge, and instret=0.
REQ-044 Scenario: CNT_W=4 with 16 consecutive j instructions -> instret reads 15 and then wraps to 0.
